// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and the per-axis bounce helper for the sprite engine.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Bar colours, index 0 is the leftmost bar.
  localparam logic [7:0][11:0] BAR_RGB = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  typedef enum logic {S_WAIT, S_MOVE} state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_t;

  // One frame of motion on one axis; compares run in 11 bits so pos+step cannot wrap.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                      input logic [10:0] maxv, input logic [10:0] step);
    axis_t      r;
    logic [10:0] p;
    p = {1'b0, pos};
    if (dir && (p + step >= maxv))
      r = '{pos: maxv[9:0], dir: 1'b0, hit: 1'b1};
    else if (!dir && (p <= step))
      r = '{pos: 10'd0, dir: 1'b1, hit: 1'b1};
    else if (dir)
      r = '{pos: pos + step[9:0], dir: 1'b1, hit: 1'b0};
    else
      r = '{pos: pos - step[9:0], dir: 1'b0, hit: 1'b0};
    return r;
  endfunction

endpackage

// File: rtl/vga_sprite_engine_if.sv
// Pixel-request / colour-response bundle between vga_driver (master) and the sprite engine (slave).
interface vga_sprite_engine_if;
  logic [9:0] I_pix_x;
  logic [9:0] I_pix_y;
  logic       I_active;
  logic       I_frame_start;
  logic       I_pause;
  logic [3:0] O_red;
  logic [3:0] O_green;
  logic [3:0] O_blue;
  logic       O_bounce;
  logic       O_corner;
  logic [7:0] O_frame_cnt;

  modport master (
    output I_pix_x, I_pix_y, I_active, I_frame_start, I_pause,
    input  O_red, O_green, O_blue, O_bounce, O_corner, O_frame_cnt
  );

  modport slave (
    input  I_pix_x, I_pix_y, I_active, I_frame_start, I_pause,
    output O_red, O_green, O_blue, O_bounce, O_corner, O_frame_cnt
  );
endinterface

// File: rtl/vga_sprite_motion.sv
// Once-per-frame sprite motion: WAIT/MOVE FSM, position/direction registers, bounce pulses, frame counter.
module vga_sprite_motion
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SPRITE_SIZE = 32,
  parameter int STEP        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       pause,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       bounce,
  output logic       corner,
  output logic [7:0] frame_cnt
);

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - SPRITE_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - SPRITE_SIZE);
  localparam logic [10:0] STP   = 11'(STEP);

  state_t state, state_nxt;
  logic   move;
  logic   dx, dy;
  axis_t  ax, ay;

  always_ff @(posedge clk) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // A frame_start seen while in S_MOVE falls through to S_WAIT and is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: if (frame_start && !pause) state_nxt = S_MOVE;
      S_MOVE: state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    move = (state == S_MOVE);
    ax   = axis_step(sx, dx, X_MAX, STP);
    ay   = axis_step(sy, dy, Y_MAX, STP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx        <= '0;
      sy        <= '0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      bounce    <= 1'b0;
      corner    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      bounce <= 1'b0;
      corner <= 1'b0;
      if (move) begin
        sx        <= ax.pos;
        sy        <= ay.pos;
        dx        <= ax.dir;
        dy        <= ay.dir;
        bounce    <= ax.hit | ay.hit;
        corner    <= ax.hit & ay.hit;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vga_sprite_engine.sv
// Two-stage pixel source: bouncing square sprite over a background; colour bars when VGA_COLOR_BARS_EN is defined.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE    = H_ACTIVE_DEF,
  parameter int          V_ACTIVE    = V_ACTIVE_DEF,
  parameter int          SPRITE_SIZE = 32,
  parameter int          STEP        = 2,
  parameter logic [11:0] SPRITE_RGB  = 12'hFFF
) (
  input logic                  I_clk,
  input logic                  I_rst,
  vga_sprite_engine_if.slave   vif
);

  localparam logic [10:0] SZ = 11'(SPRITE_SIZE);

  logic [9:0]  sx, sy;
  logic        hit;
  logic        s1_hit, s1_act;
  logic [11:0] bg, rgb;

  vga_sprite_motion #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .SPRITE_SIZE(SPRITE_SIZE), .STEP(STEP)
  ) u_motion (
    .clk(I_clk), .rst(I_rst),
    .frame_start(vif.I_frame_start), .pause(vif.I_pause),
    .sx(sx), .sy(sy),
    .bounce(vif.O_bounce), .corner(vif.O_corner), .frame_cnt(vif.O_frame_cnt)
  );

  always_comb
    hit = ({1'b0, vif.I_pix_x} >= {1'b0, sx}) && ({1'b0, vif.I_pix_x} < {1'b0, sx} + SZ) &&
          ({1'b0, vif.I_pix_y} >= {1'b0, sy}) && ({1'b0, vif.I_pix_y} < {1'b0, sy} + SZ);

`ifdef VGA_COLOR_BARS_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar, s1_bar;

  // Comparator chain against constant bar edges; anything past the last edge stays in bar 7.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++)
      if (vif.I_pix_x >= 10'(i * BAR_W)) bar = 3'(i);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) s1_bar <= '0;
    else       s1_bar <= bar;
  end

  always_comb bg = BAR_RGB[s1_bar];
`else
  always_comb bg = 12'h000;
`endif

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      s1_hit <= 1'b0;
      s1_act <= 1'b0;
    end else begin
      s1_hit <= hit;
      s1_act <= vif.I_active;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst)        rgb <= '0;
    else if (!s1_act) rgb <= '0;
    else if (s1_hit)  rgb <= SPRITE_RGB;
    else              rgb <= bg;
  end

  assign vif.O_red   = rgb[11:8];
  assign vif.O_green = rgb[7:4];
  assign vif.O_blue  = rgb[3:0];

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine: per-cycle reference model plus literal spot checks.
module tb_vga_sprite_engine;

  localparam int H = 640, V = 480, SZ = 32, ST = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   go  = 1'b0;
  int   errs = 0, checks = 0;

  always #5 clk = ~clk;

  vga_sprite_engine_if bus ();
  vga_sprite_engine_if bus2 ();

  vga_sprite_engine #(.H_ACTIVE(H), .V_ACTIVE(V), .SPRITE_SIZE(SZ), .STEP(ST), .SPRITE_RGB(12'hFFF))
    dut (.I_clk(clk), .I_rst(rst), .vif(bus));

  vga_sprite_engine #(.H_ACTIVE(64), .V_ACTIVE(64), .SPRITE_SIZE(32), .STEP(2), .SPRITE_RGB(12'hFFF))
    dut2 (.I_clk(clk), .I_rst(rst), .vif(bus2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit axis_hit(input int p, input bit d, input int mx);
    return d ? (p + ST >= mx) : (p <= ST);
  endfunction

  function automatic int axis_pos(input int p, input bit d, input int mx);
    if (axis_hit(p, d, mx)) return d ? mx : 0;
    return d ? p + ST : p - ST;
  endfunction

  function automatic logic [11:0] bar_rgb(input int x);
    int idx;
    idx = x / (H / 8);
    if (idx > 7) idx = 7;
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] pix_rgb(input int x, input int y, input bit act, input int sx, input int sy);
    if (!act) return 12'h000;
    if (x >= sx && x < sx + SZ && y >= sy && y < sy + SZ) return 12'hFFF;
`ifdef VGA_COLOR_BARS_EN
    return bar_rgb(x);
`else
    return 12'h000;
`endif
  endfunction

  int          m_sx, m_sy, m_cnt;
  bit          m_dx, m_dy, m_pend, m_b, m_c;
  logic [11:0] s1_e, s2_e;

  always @(posedge clk) begin
    if (rst) begin
      m_sx <= 0; m_sy <= 0; m_dx <= 1'b1; m_dy <= 1'b1;
      m_pend <= 1'b0; m_b <= 1'b0; m_c <= 1'b0; m_cnt <= 0;
      s1_e <= 12'h000; s2_e <= 12'h000;
    end else begin
      s1_e <= pix_rgb(int'(bus.I_pix_x), int'(bus.I_pix_y), bus.I_active, m_sx, m_sy);
      s2_e <= s1_e;
      m_b <= 1'b0;
      m_c <= 1'b0;
      if (m_pend) begin
        m_sx  <= axis_pos(m_sx, m_dx, H - SZ);
        m_sy  <= axis_pos(m_sy, m_dy, V - SZ);
        m_dx  <= m_dx ^ axis_hit(m_sx, m_dx, H - SZ);
        m_dy  <= m_dy ^ axis_hit(m_sy, m_dy, V - SZ);
        m_b   <= axis_hit(m_sx, m_dx, H - SZ) | axis_hit(m_sy, m_dy, V - SZ);
        m_c   <= axis_hit(m_sx, m_dx, H - SZ) & axis_hit(m_sy, m_dy, V - SZ);
        m_cnt <= (m_cnt + 1) % 256;
        m_pend <= 1'b0;
      end else if (bus.I_frame_start && !bus.I_pause) begin
        m_pend <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("rgb", {bus.O_red, bus.O_green, bus.O_blue}, s2_e);
      chk("bounce", bus.O_bounce, m_b);
      chk("corner", bus.O_corner, m_c);
      chk("frame_cnt", bus.O_frame_cnt, m_cnt);
      chk("sx", dut.u_motion.sx, m_sx);
      chk("sy", dut.u_motion.sy, m_sy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic px_chk(input string name, input int x, input int y, input bit a, input logic [11:0] exp);
    bus.I_pix_x  = 10'(x);
    bus.I_pix_y  = 10'(y);
    bus.I_active = a;
    repeat (2) @(negedge clk);
    chk(name, {bus.O_red, bus.O_green, bus.O_blue}, exp);
  endtask

  task automatic frame(input bit second, output bit b, output bit c);
    if (second) bus2.I_frame_start = 1'b1; else bus.I_frame_start = 1'b1;
    @(negedge clk);
    bus.I_frame_start = 1'b0;
    bus2.I_frame_start = 1'b0;
    @(negedge clk);
    b = second ? bus2.O_bounce : bus.O_bounce;
    c = second ? bus2.O_corner : bus.O_corner;
    @(negedge clk);
  endtask

`ifdef VGA_COLOR_BARS_EN
  localparam logic [11:0] BG_100 = 12'hFF0;
  localparam logic [11:0] BG_1   = 12'hFFF;
`else
  localparam logic [11:0] BG_100 = 12'h000;
  localparam logic [11:0] BG_1   = 12'h000;
`endif

  initial begin
    bit b, c;
    bus.I_pix_x = '0; bus.I_pix_y = '0; bus.I_active = 1'b0;
    bus.I_frame_start = 1'b0; bus.I_pause = 1'b0;
    bus2.I_pix_x = '0; bus2.I_pix_y = '0; bus2.I_active = 1'b0;
    bus2.I_frame_start = 1'b0; bus2.I_pause = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    go = 1'b1;
    chk("reset_rgb", {bus.O_red, bus.O_green, bus.O_blue}, 12'h000);
    chk("reset_cnt", bus.O_frame_cnt, 8'd0);
    chk("reset_bounce", {bus.O_bounce, bus.O_corner}, 2'b00);
    rst = 1'b0;

    // sprite at origin, bar and blanking
    px_chk("origin_sprite", 0, 0, 1'b1, 12'hFFF);
    px_chk("bg_100_200", 100, 200, 1'b1, BG_100);
    px_chk("blank_100_200", 100, 200, 1'b0, 12'h000);
    px_chk("bar_last_edge", 639, 400, 1'b1, pix_rgb(639, 400, 1'b1, 0, 0));

    // one frame
    frame(1'b0, b, c);
    chk("f1_cnt", bus.O_frame_cnt, 8'd1);
    chk("f1_sx", dut.u_motion.sx, 10'd2);
    chk("f1_sy", dut.u_motion.sy, 10'd2);
    px_chk("f1_in_33_33", 33, 33, 1'b1, 12'hFFF);
    px_chk("f1_out_1_1", 1, 1, 1'b1, BG_1);
    px_chk("f1_edge_34_34", 34, 34, 1'b1, BG_1);

    // frame_start held into S_MOVE is ignored
    bus.I_frame_start = 1'b1;
    repeat (2) @(negedge clk);
    bus.I_frame_start = 1'b0;
    @(negedge clk);
    chk("fs_in_move_cnt", bus.O_frame_cnt, 8'd2);

    // pause rising during S_MOVE does not cancel the update
    bus.I_frame_start = 1'b1;
    @(negedge clk);
    bus.I_frame_start = 1'b0;
    bus.I_pause = 1'b1;
    repeat (2) @(negedge clk);
    bus.I_pause = 1'b0;
    chk("pause_in_move_cnt", bus.O_frame_cnt, 8'd3);

    // 303 frames from reset, then the right-edge bounce
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (303) frame(1'b0, b, c);
    chk("f303_sx", dut.u_motion.sx, 10'd606);
    chk("f303_dx", dut.u_motion.dx, 1'b1);
    chk("f303_bounce", b, 1'b0);
    frame(1'b0, b, c);
    chk("f304_sx", dut.u_motion.sx, 10'd608);
    chk("f304_dx", dut.u_motion.dx, 1'b0);
    chk("f304_sy", dut.u_motion.sy, 10'd288);
    chk("f304_bounce", b, 1'b1);
    chk("f304_corner", c, 1'b0);
    chk("f304_cnt", bus.O_frame_cnt, 8'd48);

    // small screen: diagonal run into the corner
    repeat (15) frame(1'b1, b, c);
    chk("small_f15_bounce", b, 1'b0);
    frame(1'b1, b, c);
    chk("small_f16_bounce", b, 1'b1);
    chk("small_f16_corner", c, 1'b1);
    chk("small_f16_sx", dut2.u_motion.sx, 10'd32);

    // pause freezes motion and counting
    bus.I_pause = 1'b1;
    repeat (5) frame(1'b0, b, c);
    bus.I_pause = 1'b0;
    chk("pause_cnt", bus.O_frame_cnt, 8'd48);
    chk("pause_sx", dut.u_motion.sx, 10'd608);
    chk("pause_sy", dut.u_motion.sy, 10'd288);

    // mid-line reset
    px_chk("pre_rst_sprite", 610, 290, 1'b1, 12'hFFF);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rgb", {bus.O_red, bus.O_green, bus.O_blue}, 12'h000);
    chk("midrst_cnt", bus.O_frame_cnt, 8'd0);
    chk("midrst_pulses", {bus.O_bounce, bus.O_corner}, 2'b00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/vga_sprite_engine.md
# vga_sprite_engine

Pixel-source stage that sits directly upstream of `vga_driver`, supplying its 12-bit RGB. It takes the driver's current pixel coordinates and active-video flag and returns the colour for that pixel two cycles later. The picture is a background of colour bars with a solid square sprite that moves diagonally and bounces off the screen edges. The sprite position advances once per frame, during vertical blanking, so there is no tearing.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `SPRITE_SIZE`, 32: sprite edge length in pixels.
- `STEP`, 2: pixels moved per axis per frame. Legal range is 1 to `SPRITE_SIZE`.
- `SPRITE_RGB`, 12'hFFF: sprite colour, as {R,G,B} with 4 bits each.

Ports:
- `I_clk`, in, 1: pixel clock.
- `I_rst`, in, 1: synchronous, active-high reset.
- `I_pix_x`, in, 10: current column, from the driver.
- `I_pix_y`, in, 10: current row, from the driver.
- `I_active`, in, 1: high when the driver is in the visible area.
- `I_frame_start`, in, 1: one-cycle pulse at the start of vertical blanking.
- `I_pause`, in, 1: while high, the sprite does not move.
- `O_red`, `O_green`, `O_blue`, out, 4 each: pixel colour.
- `O_bounce`, out, 1: one-cycle pulse when either axis reverses direction.
- `O_corner`, out, 1: one-cycle pulse when both axes reverse in the same update.
- `O_frame_cnt`, out, 8: count of frame updates, wraps at 255.

## Operation
Motion controller FSM:
- States are `S_WAIT` and `S_MOVE`.
- `S_WAIT` → `S_MOVE` when `I_frame_start` is high and `I_pause` is low.
- `S_MOVE` → `S_WAIT` unconditionally after one cycle.
- The position update happens in the `S_MOVE` cycle.

Position registers:
- `sx` (10 bits) and `sy` (10 bits) hold the sprite's top-left corner.
- `dx` and `dy` are 1-bit directions: 1 means increasing, 0 means decreasing.

Per-axis update rule (X shown; Y is identical with `V_ACTIVE`). Let MAX = `H_ACTIVE` − `SPRITE_SIZE`.
- `dx`=1 and `sx`+`STEP` ≥ MAX: set `sx` = MAX and clear `dx`. This counts as a bounce.
- `dx`=0 and `sx` ≤ `STEP`: set `sx` = 0 and set `dx`. This counts as a bounce.
- Otherwise: `sx` ± `STEP`.
- Do the compare in 11 bits so it cannot wrap.

Pulses and counter:
- `O_bounce` pulses in the cycle after `S_MOVE` if either axis bounced.
- `O_corner` pulses in that same cycle if both axes bounced.
- `O_frame_cnt` increments in every `S_MOVE` cycle. Frames skipped under pause are not counted.

Pixel path:
- A pixel is inside the sprite when `sx` ≤ `I_pix_x` < `sx`+`SPRITE_SIZE` and `sy` ≤ `I_pix_y` < `sy`+`SPRITE_SIZE`.
- Priority, highest first:
  1. `I_active`=0 → black.
  2. Inside sprite → `SPRITE_RGB`.
  3. Otherwise → background.

Boundary conditions:
- `I_frame_start` arriving while in `S_MOVE` is ignored.
- `I_pause` rising during `S_MOVE` has no effect on the update already under way.
- Coordinates outside the visible area with `I_active`=1 are not checked; the priority rules apply as written.

## Timing
- Latency is exactly 2 cycles from `I_pix_x`/`I_pix_y`/`I_active` to RGB.
  - Stage 1 registers the sprite-hit flag, the bar index and `I_active`.
  - Stage 2 registers the RGB.
  - `vga_driver` delays its hs/vs by 2 cycles to stay aligned.
- A position change becomes visible from the pixel sampled 2 cycles after the update. The update always falls inside blanking, so the visible frame uses a single position.

Reset values (`I_rst` high):
- `sx`=0, `sy`=0, `dx`=1, `dy`=1.
- FSM in `S_WAIT`.
- Both pipeline stages cleared, so `O_red`/`O_green`/`O_blue` = 0.
- `O_bounce`=0, `O_corner`=0, `O_frame_cnt`=0.

Reset in the middle of a frame clears everything on the next edge. Output is black for 2 cycles after reset is released.

## Configuration
`VGA_COLOR_BARS_EN`:
- Defined:
  - The background is 8 vertical bars, each `H_ACTIVE`/8 pixels wide (80 at default).
  - Left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - The bar index is derived in stage 1 with a chain of constant comparators, not a divider.
- Undefined:
  - The background is 12'h000.
  - The bar logic is removed.

## Structure
- Package `vga_pkg` holds:
  - The default `H_ACTIVE` and `V_ACTIVE`.
  - The 8 bar colour constants.
  - The FSM state typedef.
- Sub-module `vga_sprite_motion` contains the FSM, the position and direction registers, `O_bounce`/`O_corner` and the frame counter. It exports `sx` and `sy`.
- The top level holds the two-stage pixel pipeline.

## Test plan
1. Reset, then pixel (0,0) with `I_active`=1 → after 2 cycles RGB = FFF (sprite at 0,0).
2. Pixel (100,200) with `I_active`=1, macro defined → FF0 after 2 cycles. Same input with `I_active`=0 → 000.
3. 1 `I_frame_start` pulse → `sx`=2, `sy`=2, `O_frame_cnt`=1. Pixel (33,33) → FFF; pixel (1,1) → bar colour.
4. 303 frames starting from reset → `sx`=606, `dx`=1, no bounce. The next frame → `sx`=608, `dx`=0, `O_bounce` pulses, `O_corner`=0.
5. Diagonal run to a corner with `H_ACTIVE`=`V_ACTIVE`=64, `SPRITE_SIZE`=32, `STEP`=2 → after frame 16 both axes bounce, and `O_bounce` and `O_corner` pulse in the same cycle.
6. `I_pause`=1 over 5 frame pulses → `sx`, `sy` and `O_frame_cnt` unchanged. Assert `I_rst` in the middle of a line → all outputs 0 on the next edge.
